// File: rtl/rtc_bus_cycle_gen_if.sv
// RTC multiplexed-bus cycle interface: sequencer request side plus
// the active-low strobes and phase flags the generator drives.
interface rtc_bus_cycle_gen_if;
  logic       do_it;
  logic       w_r;
  logic [7:0] dato_rtc;
  logic       a_d;
  logic       cs;
  logic       rd;
  logic       wr;
  logic       send_add;
  logic       send_data;
  logic       read_data;
  logic [7:0] dato_leido;
  logic       ciclo_fin;

  modport master (
    input  do_it, w_r, dato_rtc,
    output a_d, cs, rd, wr,
    output send_add, send_data, read_data,
    output dato_leido, ciclo_fin
  );

  modport slave (
    output do_it, w_r, dato_rtc,
    input  a_d, cs, rd, wr,
    input  send_add, send_data, read_data,
    input  dato_leido, ciclo_fin
  );
endinterface

// File: rtl/rtc_bus_cycle_gen.sv
// Timed Intel-style address/data cycle generator for the RTC port.
// One request yields ADDR, GAP, DATA, REC phases (35 clocks default).
module rtc_bus_cycle_gen #(
  parameter int T_ADDR = 10,
  parameter int T_GAP  = 5,
  parameter int T_DATA = 10,
  parameter int T_REC  = 10
) (
  input  logic clk,
  input  logic reset,
  rtc_bus_cycle_gen_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, GAP, DATA, REC
  } state_t;

  localparam logic [7:0] A_END = 8'(T_ADDR - 1);
  localparam logic [7:0] G_END = 8'(T_GAP - 1);
  localparam logic [7:0] D_END = 8'(T_DATA - 1);
  localparam logic [7:0] R_END = 8'(T_REC - 1);

  state_t     state;
  state_t     nxt;
  logic [7:0] cnt;
  logic       wr_lat;
  logic [7:0] dato_q;
  logic       last;

  always_comb begin
    last = 1'b0;
    unique case (state)
      ADDR:    last = (cnt == A_END);
      GAP:     last = (cnt == G_END);
      DATA:    last = (cnt == D_END);
      REC:     last = (cnt == R_END);
      default: last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      wr_lat <= 1'b1;
      dato_q <= '0;
    end else begin
      state <= nxt;
      if (nxt != state || state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 8'd1;
      // direction is frozen for the whole cycle
      if (nxt == ADDR && state != ADDR)
        wr_lat <= bus.w_r;
      if (state == DATA && last && !wr_lat)
        dato_q <= bus.dato_rtc;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bus.do_it) nxt = ADDR;
      ADDR: if (last) nxt = GAP;
      GAP:  if (last) nxt = DATA;
      DATA: if (last) nxt = REC;
      REC:  if (last) nxt = bus.do_it ? ADDR : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.a_d       = 1'b1;
    bus.cs        = 1'b1;
    bus.rd        = 1'b1;
    bus.wr        = 1'b1;
    bus.send_add  = 1'b0;
    bus.send_data = 1'b0;
    bus.read_data = 1'b0;
    bus.ciclo_fin = 1'b0;
    unique case (state)
      ADDR: begin
        bus.a_d      = 1'b0;
        bus.cs       = 1'b0;
        bus.wr       = 1'b0;
        bus.send_add = 1'b1;
      end
      DATA: begin
        bus.cs = 1'b0;
        if (wr_lat) begin
          bus.wr        = 1'b0;
          bus.send_data = 1'b1;
        end else begin
          bus.rd = 1'b0;
        end
      end
      REC: begin
        bus.read_data = (cnt == 8'd0) && !wr_lat;
        bus.ciclo_fin = last;
      end
      default: ;
    endcase
  end

  assign bus.dato_leido = dato_q;

endmodule

// File: tb/tb_rtc_bus_cycle_gen.sv
// Bench for rtc_bus_cycle_gen: offset-based reference model,
// directed cycles plus randomized request/direction/data traffic.
module tb_rtc_bus_cycle_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_bus_cycle_gen_if bus ();

  rtc_bus_cycle_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int PER = 35;

  int total = 0;
  int bad   = 0;
  int fin_cnt = 0;

  bit         m_act;
  int         m_off;
  bit         m_wr;
  logic [7:0] m_dato;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  // {a_d,cs,rd,wr,send_add,send_data,read_data,ciclo_fin}
  function automatic logic [7:0] exp_vec();
    logic [7:0] v;
    v = 8'b1111_0000;
    if (m_act) begin
      if (m_off < 10)
        v = 8'b0010_1000;
      else if (m_off < 15)
        v = 8'b1111_0000;
      else if (m_off < 25)
        v = m_wr ? 8'b1010_0100 : 8'b1001_0000;
      else begin
        v = 8'b1111_0000;
        v[1] = (m_off == 25) && !m_wr;
        v[0] = (m_off == PER - 1);
      end
    end
    return v;
  endfunction

  function automatic void model_step();
    if (reset) begin
      m_act  = 1'b0;
      m_dato = 8'h00;
    end else if (!m_act) begin
      if (bus.do_it) begin
        m_act = 1'b1;
        m_off = 0;
        m_wr  = bus.w_r;
      end
    end else begin
      if (m_off == 24 && !m_wr)
        m_dato = bus.dato_rtc;
      if (m_off == PER - 1) begin
        if (bus.do_it) begin
          m_off = 0;
          m_wr  = bus.w_r;
        end else begin
          m_act = 1'b0;
        end
      end else begin
        m_off++;
      end
    end
  endfunction

  task automatic compare();
    logic [7:0] v;
    v = {bus.a_d, bus.cs, bus.rd, bus.wr,
         bus.send_add, bus.send_data,
         bus.read_data, bus.ciclo_fin};
    chk("outputs", 32'(v), 32'(exp_vec()));
    chk("dato_leido", 32'(bus.dato_leido), 32'(m_dato));
    chk("rd_wr_excl", 32'(bus.rd | bus.wr), 32'd1);
    chk("flags_excl",
        32'(!(bus.send_add && bus.send_data)), 32'd1);
    chk("cs_on_strobe",
        32'(!((!bus.rd || !bus.wr) && bus.cs)), 32'd1);
    if (bus.ciclo_fin === 1'b1)
      fin_cnt++;
  endtask

  task automatic step(input bit d, input bit w,
                      input logic [7:0] x);
    bus.do_it    = d;
    bus.w_r      = w;
    bus.dato_rtc = x;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    reset        = 1'b1;
    bus.do_it    = 1'b0;
    bus.w_r      = 1'b0;
    bus.dato_rtc = 8'h00;
    m_act  = 1'b0;
    m_off  = 0;
    m_wr   = 1'b1;
    m_dato = 8'h00;
    #1;
    compare();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 8'h00);

    // single write, w_r flips to read at c12
    step(1, 1, 8'h11);
    for (int i = 1; i <= 40; i++)
      step(0, (i >= 12) ? 1'b0 : 1'b1, 8'($urandom));

    // single read returning 0x5A
    step(1, 0, 8'h00);
    for (int i = 1; i <= 40; i++)
      step(0, 1'b0, 8'h5A);
    chk("read_5a", 32'(bus.dato_leido), 32'h5A);

    // do_it dropped at c5
    for (int i = 0; i < 5; i++)
      step(1, 1, 8'h00);
    for (int i = 5; i <= 40; i++)
      step(0, 1, 8'h00);

    // 385 clocks of do_it: eleven back-to-back cycles
    fin_cnt = 0;
    for (int i = 0; i < 11 * PER; i++)
      step(1, 1'($urandom), 8'($urandom));
    for (int i = 0; i < 40; i++)
      step(0, 0, 8'($urandom));
    chk("b2b_cycles", 32'(fin_cnt), 32'd11);

    // reset in the middle of a write DATA phase
    step(1, 1, 8'h00);
    for (int i = 1; i <= 19; i++)
      step(0, 1, 8'h00);
    #2 reset = 1'b1;
    #1;
    m_act  = 1'b0;
    m_dato = 8'h00;
    compare();
    step(0, 1, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 40; i++)
      step(0, 1, 8'h00);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      step($urandom_range(0, 9) < 4,
           1'($urandom), 8'($urandom));
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++)
      step(0, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
